ft232h_tx_writer: RTL

Transmit-direction counterpart of the FT232H receive path. Drains bytes from the FPGA-to-PC FIFO (show-ahead, clk60 domain) into the FT232H synchronous-FIFO write port using TXEn/WRn and the shared 8-bit data bus. Sits beside FT232H_Interface2, which owns bus arbitration and grants the bus to this block for transmit bursts.

---
 rtl/ft232h_tx_writer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ft232h_tx_writer.sv
// Purpose : drains the show-ahead outbound FIFO into the FT232H sync-FIFO write port.
// Latency : FIFO byte on TOPC one cycle after rdreq; sustains 1 byte/cycle while TXEn stays low.
// Backpr. : TXEn high holds the pending byte on TOPC (no rdreq); grant loss keeps it for the next grant.
//
// Ports:
//   clk60, RSTn              - FT232H CLKOUT, async active-low reset
//   tx_grant                 - arbiter grant of the shared bus for transmit
//   rdempty, q, rdreq        - show-ahead FIFO interface (rdreq is combinational)
//   TXEn, WRn, TOPC, bus_oe  - FT232H write side and tri-state enable
//   tx_release               - pulse on the accept that completes a MAX_BURST burst
//   byte_count               - bytes accepted by the FT232H since reset (wraps)
//   SIWUn                    - send-immediate pulse, only built with macro FT_SIWU_EN
module ft232h_tx_writer #(
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic        clk60,
    input  logic        RSTn,
    input  logic        tx_grant,
    input  logic        rdempty,
    input  logic [7:0]  q,
    output logic        rdreq,
    input  logic        TXEn,
    output logic        WRn,
    output logic [7:0]  TOPC,
    output logic        bus_oe,
    output logic        tx_release,
    output logic [15:0] byte_count,
    output logic        SIWUn
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_out_v;
    logic        r_bus_oe;
    logic [7:0]  r_topc;
    logic [7:0]  r_burst_cnt;
    logic [15:0] r_byte_count;

    logic        w_accept;
    logic        w_last;
    logic        w_load;
    logic        w_release;

    // The FT232H latches the byte on any edge where WRn and TXEn are both low;
    // WRn itself is a pure function of flops so it is glitch-free on the pad.
    assign w_accept = r_out_v & r_bus_oe & ~TXEn;
    assign w_last   = w_accept && (r_burst_cnt == 8'(MAX_BURST - 1));
    // Refill the output register when it is empty or being emptied this edge.
    assign w_load   = tx_grant && (r_state == S_XFER) && !rdempty && (!r_out_v || w_accept);

    assign rdreq      = w_load;
    assign WRn        = ~(r_out_v & r_bus_oe);
    assign TOPC       = r_topc;
    assign bus_oe     = r_bus_oe;
    assign tx_release = w_release;
    assign byte_count = r_byte_count;

    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_grant) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                    w_release   = 1'b1;
                end else if (!tx_grant) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!tx_grant) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk60 or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= S_IDLE;
            r_bus_oe     <= 1'b0;
            r_out_v      <= 1'b0;
            r_topc       <= 8'h00;
            r_burst_cnt  <= 8'h00;
            r_byte_count <= 16'h0000;
        end else begin
            r_state  <= w_state_nxt;
            // Driving the bus exactly while in XFER keeps bus_oe one edge behind grant.
            r_bus_oe <= (w_state_nxt == S_XFER);

            if (w_load) begin
                r_topc  <= q;
                r_out_v <= 1'b1;
            end else if (w_accept) begin
                r_out_v <= 1'b0;
            end

            if (r_state == S_IDLE && w_state_nxt == S_XFER) begin
                r_burst_cnt <= 8'h00;
            end else if (w_accept) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end

            if (w_accept) r_byte_count <= r_byte_count + 16'd1;
        end
    end

`ifdef FT_SIWU_EN
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    logic [IW-1:0] r_idle_cnt;
    logic          r_armed;
    logic          r_siwu_n;

    // Counter starts at 1 on the accepting edge so SIWUn falls IDLE_TIMEOUT
    // edges after the accept; the armed flag limits it to one pulse per idle gap.
    always_ff @(posedge clk60 or negedge RSTn) begin
        if (!RSTn) begin
            r_idle_cnt <= '0;
            r_armed    <= 1'b0;
            r_siwu_n   <= 1'b1;
        end else begin
            r_siwu_n <= 1'b1;
            if (w_accept) begin
                r_idle_cnt <= IW'(1);
                r_armed    <= 1'b1;
            end else if (r_armed) begin
                if (r_idle_cnt != IW'(IDLE_TIMEOUT)) begin
                    r_idle_cnt <= r_idle_cnt + IW'(1);
                end else if (!r_out_v && rdempty) begin
                    r_siwu_n <= 1'b0;
                    r_armed  <= 1'b0;
                end
            end
        end
    end

    assign SIWUn = r_siwu_n;
`else
    assign SIWUn = 1'b1;
`endif

endmodule
